audio_adsr_envelope: RTL

//  ADSR amplitude envelope; the stage directly downstream of audio_triangle.

---
 rtl/audio_synth_pkg.sv | 16 +
 rtl/audio_tick_gen.sv | 27 ++
 rtl/audio_adsr_envelope.sv | 121 ++++++++++++
 3 files changed

// File: rtl/audio_synth_pkg.sv
// Shared types and constants for the audio synth chain.
// Envelope state encoding, sample-tick divider and offset-binary midpoint.
package audio_synth_pkg;

   typedef enum logic [2:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_DECAY,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   localparam int unsigned DIV_48KHZ  = 259;
   localparam logic [7:0]  SAMPLE_MID = 8'd128;

endpackage

// File: rtl/audio_tick_gen.sv
// Free-running sample-rate tick: one-cycle pulse every DIV+1 clocks.
// Shared by oscillators, envelope and capture so they all step on the same tick.
module audio_tick_gen #(
   parameter int unsigned DIV = 259
) (
   input  logic clk_i,
   input  logic rstn_i,
   output logic tick_o
);

   localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == CW'(DIV));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/audio_adsr_envelope.sv
// ADSR amplitude envelope: gate-driven FSM with a 16-bit level stepped on the
// 48 kHz tick, and a one-stage signed multiply that scales the offset-binary sample.
//
// state       | meaning
// ENV_IDLE    | silent, env held at 0
// ENV_ATTACK  | env ramps up by attack_rate_i per tick to full scale
// ENV_DECAY   | env ramps down by decay_rate_i per tick to sustain target
// ENV_SUSTAIN | env follows {sustain_lvl_i, 8'h00} while the gate is held
// ENV_RELEASE | env ramps down by release_rate_i per tick to 0
module audio_adsr_envelope #(
   parameter int unsigned DIV_48KHZ = audio_synth_pkg::DIV_48KHZ
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        gate_i,
   input  logic [7:0]  sample_data_i,
   input  logic [15:0] attack_rate_i,
   input  logic [15:0] decay_rate_i,
   input  logic [7:0]  sustain_lvl_i,
   input  logic [15:0] release_rate_i,
   output logic [7:0]  sample_data_o,
   output logic [7:0]  env_level_o,
   output logic [2:0]  env_state_o,
   output logic        active_o
);

   import audio_synth_pkg::*;

   env_state_t        state_q, state_d;
   logic [15:0]       env_q, env_d;
   logic              gate_q;
   logic              tick;
   logic              rise, fall;
   logic [15:0]       target;
   logic [16:0]       att_sum;
   logic [16:0]       dec_diff;
   logic signed [8:0]  smp_s;
   logic signed [17:0] prod;
   logic signed [17:0] scaled;

   audio_tick_gen #(.DIV(DIV_48KHZ)) u_tick_gen (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tick_o (tick)
   );

   assign rise     = gate_i & ~gate_q;
   assign fall     = ~gate_i & gate_q;
   assign target   = {sustain_lvl_i, 8'h00};
   assign att_sum  = {1'b0, env_q} + {1'b0, attack_rate_i};
   assign dec_diff = {1'b0, env_q} - {1'b0, decay_rate_i};

   // A gate edge always takes priority over the tick step in the same cycle.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      if (rise) begin
         state_d = ENV_ATTACK;
      end else if (fall && (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
         state_d = ENV_RELEASE;
      end else if (tick) begin
         case (state_q)
            ENV_IDLE: env_d = '0;
            ENV_ATTACK: begin
               if (attack_rate_i == '0 || att_sum >= 17'h0FFFF) begin
                  env_d   = 16'hFFFF;
                  state_d = ENV_DECAY;
               end else begin
                  env_d = att_sum[15:0];
               end
            end
            ENV_DECAY: begin
               if (decay_rate_i == '0 || target >= env_q ||
                   $signed(dec_diff) <= $signed({1'b0, target})) begin
                  env_d   = target;
                  state_d = ENV_SUSTAIN;
               end else begin
                  env_d = dec_diff[15:0];
               end
            end
            ENV_SUSTAIN: env_d = target;
            ENV_RELEASE: begin
               if (release_rate_i == '0 || env_q <= release_rate_i) begin
                  env_d   = '0;
                  state_d = ENV_IDLE;
               end else begin
                  env_d = env_q - release_rate_i;
               end
            end
            default: begin
               env_d   = '0;
               state_d = ENV_IDLE;
            end
         endcase
      end
   end

   // Signed sample times unsigned level; product magnitude stays below 2^15.
   assign smp_s  = $signed({1'b0, sample_data_i}) - 9'sd128;
   assign prod   = 18'(smp_s) * 18'($signed({1'b0, env_q[15:8]}));
   assign scaled = (prod >>> 8) + 18'sd128;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q       <= ENV_IDLE;
         env_q         <= '0;
         gate_q        <= 1'b0;
         sample_data_o <= SAMPLE_MID;
      end else begin
         state_q       <= state_d;
         env_q         <= env_d;
         gate_q        <= gate_i;
         sample_data_o <= scaled[7:0];
      end
   end

   assign env_level_o = env_q[15:8];
   assign env_state_o = state_q;
   assign active_o    = (state_q != ENV_IDLE);

endmodule
